// File: rtl/gate_response_checker.sv
// Runs the four-vector truth table through an external gate block and records which gates answered wrongly.
// Optional build macro GATE_CHK_STOP_ON_FAIL_EN ends the run on the first failing vector.
module gate_response_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       and_in,
    input  logic       nand_in,
    input  logic       or_in,
    input  logic       nor_in,
    input  logic       xor_in,
    input  logic       xnor_in,
    input  logic       not_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [6:0] fail_mask,
    output logic [1:0] fail_vec
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} StateT;

    localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

    StateT      r_state;
    StateT      w_nextState;
    logic [1:0] r_vec;
    logic [3:0] r_cnt;
    logic [2:0] r_errCount;
    logic [6:0] r_failMask;
    logic [1:0] r_failVec;

    logic       w_a;
    logic       w_b;
    logic [6:0] w_expected;
    logic [6:0] w_actual;
    logic [6:0] w_mismatch;
    logic       w_anyMismatch;

    // Expected and observed responses share the {and,nand,or,nor,xor,xnor,not} ordering of fail_mask.
    assign w_a           = r_vec[1];
    assign w_b           = r_vec[0];
    assign w_expected    = {w_a & w_b, ~(w_a & w_b), w_a | w_b, ~(w_a | w_b),
                            w_a ^ w_b, ~(w_a ^ w_b), ~w_a};
    assign w_actual      = {and_in, nand_in, or_in, nor_in, xor_in, xnor_in, not_in};
    assign w_mismatch    = w_expected ^ w_actual;
    assign w_anyMismatch = |w_mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = SETTLE;
            SETTLE:  if (r_cnt == LAST_SETTLE) w_nextState = CHECK;
            CHECK: begin
                if (r_vec == 2'd3) begin
                    w_nextState = DONE;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                end else if (w_anyMismatch) begin
                    w_nextState = DONE;
`endif
                end else begin
                    w_nextState = SETTLE;
                end
            end
            DONE:    if (start) w_nextState = SETTLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == SETTLE) || (r_state == CHECK);
        done = (r_state == DONE);
        pass = (r_state == DONE) && (r_errCount == 3'd0);
    end

    // Results only move on an accepted start or in CHECK, so DONE holds them even if the gate inputs wander.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec      <= 2'd0;
            r_cnt      <= 4'd0;
            r_errCount <= 3'd0;
            r_failMask <= 7'd0;
            r_failVec  <= 2'd0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_vec      <= 2'd0;
                        r_cnt      <= 4'd0;
                        r_errCount <= 3'd0;
                        r_failMask <= 7'd0;
                        r_failVec  <= 2'd0;
                    end
                end
                SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                end
                CHECK: begin
                    r_failMask <= r_failMask | w_mismatch;
                    if (w_anyMismatch) begin
                        r_errCount <= r_errCount + 3'd1;
                        if (r_errCount == 3'd0) begin
                            r_failVec <= r_vec;
                        end
                    end
                    if (w_nextState == SETTLE) begin
                        r_vec <= r_vec + 2'd1;
                        r_cnt <= 4'd0;
                    end
                end
                default: begin
                    r_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign a_out     = r_vec[1];
    assign b_out     = r_vec[0];
    assign err_count = r_errCount;
    assign fail_mask = r_failMask;
    assign fail_vec  = r_failVec;

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench: a fault table corrupts an ideal gate block, a reference model predicts each run's result,
// and a monitor compares whenever done rises and for as long as done is held.
module tb_gate_response_checker;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       aOut, bOut;
    logic       andIn, nandIn, orIn, norIn, xorIn, xnorIn, notIn;
    logic       busy, done, pass;
    logic [2:0] errCount;
    logic [6:0] failMask;
    logic [1:0] failVec;

    logic [6:0] corrupt [4];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int       errs;
        logic [6:0] mask;
        logic [1:0] fvec;
        logic [1:0] endVec;
        int       doneCycle;
    } ExpT;

    ExpT  expQ[$];
    ExpT  cur;
    bit   haveCur = 0;
    logic prevDone = 1'b0;

    gate_response_checker #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .a_out(aOut), .b_out(bOut),
        .and_in(andIn), .nand_in(nandIn), .or_in(orIn), .nor_in(norIn),
        .xor_in(xorIn), .xnor_in(xnorIn), .not_in(notIn),
        .busy(busy), .done(done), .pass(pass), .err_count(errCount),
        .fail_mask(failMask), .fail_vec(failVec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Truth table of a healthy gate block, written straight from the gate definitions.
    function automatic logic [6:0] ideal(input logic [1:0] v);
        logic a, b;
        a = v[1];
        b = v[0];
        return {a & b, ~(a & b), a | b, ~(a | b), a ^ b, ~(a ^ b), ~a};
    endfunction

    assign {andIn, nandIn, orIn, norIn, xorIn, xnorIn, notIn} = ideal({aOut, bOut}) ^ corrupt[{aOut, bOut}];

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Sets the fault table, predicts the outcome of the run and issues one start pulse.
    task automatic applyStimulus(input logic [6:0] c0, input logic [6:0] c1,
                                 input logic [6:0] c2, input logic [6:0] c3);
        ExpT e;
        int  nvec;
        @(negedge clk);
        corrupt[0] = c0; corrupt[1] = c1; corrupt[2] = c2; corrupt[3] = c3;
        e.errs = 0; e.mask = 7'd0; e.fvec = 2'd0; e.endVec = 2'd3; nvec = 4;
        for (int v = 0; v < 4; v++) begin
            if (corrupt[v] != 7'd0) begin
                if (e.errs == 0) e.fvec = 2'(v);
                e.errs++;
                e.mask |= corrupt[v];
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                e.endVec = 2'(v);
                nvec = v + 1;
                break;
`endif
            end
        end
        e.doneCycle = cyc + 1 + nvec * (SETTLE + 1);
        expQ.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge clk);
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL doneTimeout actual=%0d pending required=0 pending", expQ.size());
            expQ.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: pops the prediction when done rises, then holds every result against it while done stays high.
    always @(negedge clk) begin
        if (rst) begin
            prevDone = 1'b0;
        end else begin
            checkOutput("busyDoneExclusive", int'(busy && done), 0);
            if (!done) checkOutput("passLowWhenNotDone", int'(pass), 0);
            if (done && !prevDone) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedDone actual=1 required=0");
                    haveCur = 0;
                end else begin
                    cur = expQ.pop_front();
                    haveCur = 1;
                    checkOutput("latency", cyc, cur.doneCycle);
                    checkOutput("pass", int'(pass), int'(cur.errs == 0));
                end
            end
            if (done && haveCur) begin
                checkOutput("errCount", int'(errCount), cur.errs);
                checkOutput("failMask", int'(failMask), int'(cur.mask));
                checkOutput("failVec", int'(failVec), int'(cur.fvec));
                checkOutput("vecHeld", int'({aOut, bOut}), int'(cur.endVec));
            end
            prevDone = done;
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ab"}, int'({aOut, bOut}), 0);
        checkOutput({tag, "_busyDonePass"}, int'({busy, done, pass}), 0);
        checkOutput({tag, "_errCount"}, int'(errCount), 0);
        checkOutput({tag, "_failMask"}, int'(failMask), 0);
        checkOutput({tag, "_failVec"}, int'(failVec), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout actual=running required=finished");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        for (int v = 0; v < 4; v++) corrupt[v] = 7'd0;
        rst = 1'b1;
        start = 1'b0;
        #12;
        checkAllZero("resetState");
        @(negedge clk);
        rst = 1'b0;

        // Healthy block, then nand stuck at 0, not wired to ~b, xor stuck at 1.
        applyStimulus(7'd0, 7'd0, 7'd0, 7'd0);
        waitIdle();
        applyStimulus(7'b0100000, 7'b0100000, 7'b0100000, 7'd0);
        waitIdle();
        applyStimulus(7'd0, 7'b0000001, 7'b0000001, 7'd0);
        waitIdle();
        applyStimulus(7'b0000100, 7'd0, 7'd0, 7'b0000100);
        waitIdle();

        // Start re-pulsed while busy must not disturb the run or its latency.
        applyStimulus(7'd0, 7'b1000000, 7'd0, 7'b0010000);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle();

        // Asynchronous reset in the middle of vector 2's settle window.
        applyStimulus(7'b0000010, 7'd0, 7'd0, 7'd0);
        for (int i = 0; i < 50 && !(busy && aOut && !bOut); i++) @(negedge clk);
        checkOutput("reachedVec2", int'({aOut, bOut}), 2);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("midRunReset");
        expQ.delete();
        haveCur = 0;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        checkAllZero("startIgnoredInReset");
        rst = 1'b0;
        applyStimulus(7'd0, 7'd0, 7'd0, 7'd0);
        waitIdle();

        // Random fault tables; while done is held the gate inputs wander and results must not move.
        for (int run = 0; run < 20; run++) begin
            logic [6:0] c [4];
            for (int v = 0; v < 4; v++) c[v] = ($urandom_range(1, 0) == 1) ? 7'($urandom) : 7'd0;
            applyStimulus(c[0], c[1], c[2], c[3]);
            waitIdle();
            for (int k = 0; k < 3; k++) begin
                for (int v = 0; v < 4; v++) corrupt[v] = 7'($urandom);
                @(negedge clk);
            end
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
